// File: rtl/i_memory_stage.sv
// MEM stage: EX/MEM latch, branch resolve, word data memory, MEM/WB latch.
// Synchronous active-high reset clears both pipeline registers.
module i_memory_stage #(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [1:0]  wb_in,
    input  logic [2:0]  m_in,
    input  logic [31:0] add_result,
    input  logic [31:0] alu_result,
    input  logic        zero,
    input  logic [31:0] write_data,
    input  logic [4:0]  five_bit_muxout,
    output logic        pcsrc,
    output logic [31:0] branch_target,
    output logic [1:0]  wb_out,
    output logic [31:0] read_data,
    output logic [31:0] alu_result_out,
    output logic [4:0]  write_reg,
    output logic        misaligned
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef struct packed {
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [31:0] add_result;
        logic [31:0] alu_result;
        logic        zero;
        logic [31:0] write_data;
        logic [4:0]  rd;
    } ex_mem_t;

    typedef struct packed {
        logic [1:0]  wb;
        logic [31:0] read_data;
        logic [31:0] alu_result;
        logic [4:0]  rd;
        logic        misaligned;
    } mem_wb_t;

    ex_mem_t ex_mem;
    mem_wb_t mem_wb;

    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] idx;
    logic                  access;
    logic                  mis;
    logic                  do_write;
    logic [31:0]           load_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_mem <= '0;
        end else begin
            ex_mem.wb         <= flush ? 2'b00 : wb_in;
            ex_mem.m          <= flush ? 3'b000 : m_in;
            ex_mem.add_result <= add_result;
            ex_mem.alu_result <= alu_result;
            ex_mem.zero       <= zero;
            ex_mem.write_data <= write_data;
            ex_mem.rd         <= five_bit_muxout;
        end
    end

    assign pcsrc         = ex_mem.m[2] & ex_mem.zero;
    assign branch_target = ex_mem.add_result;

    // Upper address bits are dropped, so addresses alias modulo the depth.
    assign idx      = ex_mem.alu_result[DEPTH_LOG2+1:2];
    assign access   = ex_mem.m[1] | ex_mem.m[0];
    assign mis      = access & (ex_mem.alu_result[1:0] != 2'b00);
    assign do_write = ex_mem.m[0] & ~mis & ~rst;

    always_comb begin
        load_data = 32'h0;
        if (ex_mem.m[1] && !mis) begin
            load_data = mem[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[idx] <= ex_mem.write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_wb <= '0;
        end else begin
            mem_wb.wb         <= ex_mem.wb;
            mem_wb.read_data  <= load_data;
            mem_wb.alu_result <= ex_mem.alu_result;
            mem_wb.rd         <= ex_mem.rd;
            mem_wb.misaligned <= mis;
        end
    end

    assign wb_out         = mem_wb.wb;
    assign read_data      = mem_wb.read_data;
    assign alu_result_out = mem_wb.alu_result;
    assign write_reg      = mem_wb.rd;
    assign misaligned     = mem_wb.misaligned;

endmodule

// File: tb/tb_i_memory_stage.sv
// Directed bench for i_memory_stage: reset, store/load, branch,
// flush, misalignment, aliasing and read/write overlap.
module tb_i_memory_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [1:0]  wb_in;
    logic [2:0]  m_in;
    logic [31:0] add_result;
    logic [31:0] alu_result;
    logic        zero;
    logic [31:0] write_data;
    logic [4:0]  five_bit_muxout;
    logic        pcsrc;
    logic [31:0] branch_target;
    logic [1:0]  wb_out;
    logic [31:0] read_data;
    logic [31:0] alu_result_out;
    logic [4:0]  write_reg;
    logic        misaligned;

    int total = 0;
    int bad = 0;

    i_memory_stage #(.DEPTH_LOG2(8)) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .wb_in(wb_in),
        .m_in(m_in),
        .add_result(add_result),
        .alu_result(alu_result),
        .zero(zero),
        .write_data(write_data),
        .five_bit_muxout(five_bit_muxout),
        .pcsrc(pcsrc),
        .branch_target(branch_target),
        .wb_out(wb_out),
        .read_data(read_data),
        .alu_result_out(alu_result_out),
        .write_reg(write_reg),
        .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] w, input logic [2:0] m,
                         input logic [31:0] a, input logic [31:0] alu,
                         input logic z, input logic [31:0] d,
                         input logic [4:0] r);
        wb_in = w;
        m_in = m;
        add_result = a;
        alu_result = alu;
        zero = z;
        write_data = d;
        five_bit_muxout = r;
    endtask

    task automatic idle;
        drive(2'b00, 3'b000, 32'h0, 32'h0, 1'b0, 32'h0, 5'd0);
    endtask

    task automatic test_reset;
        drive(2'b11, 3'b111, 32'h44, 32'h13, 1'b1, 32'h99, 5'd9);
        flush = 1'b0;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        idle;
        total++;
        if (wb_out !== 2'b00) begin bad++;
            $display("FAIL reset_wb got=%h exp=0", wb_out); end
        total++;
        if (read_data !== 32'h0) begin bad++;
            $display("FAIL reset_rd got=%h exp=0", read_data); end
        total++;
        if (write_reg !== 5'd0) begin bad++;
            $display("FAIL reset_wreg got=%h exp=0", write_reg); end
        total++;
        if (pcsrc !== 1'b0) begin bad++;
            $display("FAIL reset_pcsrc got=%b exp=0", pcsrc); end
        total++;
        if (misaligned !== 1'b0) begin bad++;
            $display("FAIL reset_mis got=%b exp=0", misaligned); end
        total++;
        if (alu_result_out !== 32'h0) begin bad++;
            $display("FAIL reset_alu got=%h exp=0", alu_result_out); end
    endtask

    task automatic test_store_load;
        drive(2'b00, 3'b001, 32'h0, 32'h10, 1'b0, 32'hDEADBEEF, 5'd0);
        tick;
        drive(2'b11, 3'b010, 32'h0, 32'h10, 1'b0, 32'h0, 5'd5);
        tick;
        idle;
        tick;
        total++;
        if (read_data !== 32'hDEADBEEF) begin bad++;
            $display("FAIL sl_data got=%h exp=deadbeef", read_data); end
        total++;
        if (write_reg !== 5'd5) begin bad++;
            $display("FAIL sl_wreg got=%0d exp=5", write_reg); end
        total++;
        if (wb_out !== 2'b11) begin bad++;
            $display("FAIL sl_wb got=%b exp=11", wb_out); end
        total++;
        if (alu_result_out !== 32'h10) begin bad++;
            $display("FAIL sl_alu got=%h exp=10", alu_result_out); end
        total++;
        if (misaligned !== 1'b0) begin bad++;
            $display("FAIL sl_mis got=%b exp=0", misaligned); end
    endtask

    task automatic test_branch;
        drive(2'b00, 3'b100, 32'h40, 32'h0, 1'b1, 32'h0, 5'd0);
        tick;
        total++;
        if (pcsrc !== 1'b1) begin bad++;
            $display("FAIL br_taken got=%b exp=1", pcsrc); end
        total++;
        if (branch_target !== 32'h40) begin bad++;
            $display("FAIL br_tgt got=%h exp=40", branch_target); end
        drive(2'b00, 3'b100, 32'h80, 32'h4, 1'b0, 32'h0, 5'd0);
        tick;
        total++;
        if (pcsrc !== 1'b0) begin bad++;
            $display("FAIL br_nt got=%b exp=0", pcsrc); end
        total++;
        if (branch_target !== 32'h80) begin bad++;
            $display("FAIL br_tgt2 got=%h exp=80", branch_target); end
        drive(2'b10, 3'b000, 32'h0, 32'h0, 1'b1, 32'h0, 5'd1);
        tick;
        total++;
        if (pcsrc !== 1'b0) begin bad++;
            $display("FAIL br_nobr got=%b exp=0", pcsrc); end
        idle;
        tick;
    endtask

    task automatic test_flush;
        drive(2'b00, 3'b001, 32'h0, 32'h20, 1'b0, 32'h5555, 5'd0);
        tick;
        flush = 1'b1;
        drive(2'b11, 3'b101, 32'h0, 32'h20, 1'b1, 32'h1234, 5'd7);
        tick;
        flush = 1'b0;
        total++;
        if (pcsrc !== 1'b0) begin bad++;
            $display("FAIL fl_pcsrc got=%b exp=0", pcsrc); end
        idle;
        tick;
        total++;
        if (wb_out !== 2'b00) begin bad++;
            $display("FAIL fl_wb got=%b exp=00", wb_out); end
        total++;
        if (write_reg !== 5'd7) begin bad++;
            $display("FAIL fl_wreg got=%0d exp=7", write_reg); end
        drive(2'b11, 3'b010, 32'h0, 32'h20, 1'b0, 32'h0, 5'd3);
        tick;
        idle;
        tick;
        total++;
        if (read_data !== 32'h5555) begin bad++;
            $display("FAIL fl_mem got=%h exp=5555", read_data); end
        // flush must not cancel a store already latched
        drive(2'b00, 3'b001, 32'h0, 32'h24, 1'b0, 32'hAAAA, 5'd0);
        tick;
        idle;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        drive(2'b11, 3'b010, 32'h0, 32'h24, 1'b0, 32'h0, 5'd4);
        tick;
        idle;
        tick;
        total++;
        if (read_data !== 32'hAAAA) begin bad++;
            $display("FAIL fl_inflight got=%h exp=aaaa", read_data); end
    endtask

    task automatic test_misaligned;
        drive(2'b00, 3'b001, 32'h0, 32'h13, 1'b0, 32'hBAD, 5'd0);
        tick;
        drive(2'b11, 3'b010, 32'h0, 32'h12, 1'b0, 32'h0, 5'd6);
        tick;
        total++;
        if (misaligned !== 1'b1) begin bad++;
            $display("FAIL mis_st got=%b exp=1", misaligned); end
        drive(2'b11, 3'b010, 32'h0, 32'h10, 1'b0, 32'h0, 5'd6);
        tick;
        total++;
        if (misaligned !== 1'b1) begin bad++;
            $display("FAIL mis_ld got=%b exp=1", misaligned); end
        total++;
        if (read_data !== 32'h0) begin bad++;
            $display("FAIL mis_ld_data got=%h exp=0", read_data); end
        idle;
        tick;
        total++;
        if (read_data !== 32'hDEADBEEF) begin bad++;
            $display("FAIL mis_nowrite got=%h exp=deadbeef", read_data); end
        total++;
        if (misaligned !== 1'b0) begin bad++;
            $display("FAIL mis_clear got=%b exp=0", misaligned); end
    endtask

    task automatic test_alias;
        drive(2'b00, 3'b001, 32'h0, 32'h3FC, 1'b0, 32'h0BAD0BAD, 5'd0);
        tick;
        drive(2'b00, 3'b001, 32'h0, 32'h400, 1'b0, 32'hCAFEF00D, 5'd0);
        tick;
        drive(2'b11, 3'b010, 32'h0, 32'h000, 1'b0, 32'h0, 5'd8);
        tick;
        drive(2'b11, 3'b010, 32'h0, 32'h3FC, 1'b0, 32'h0, 5'd8);
        tick;
        total++;
        if (read_data !== 32'hCAFEF00D) begin bad++;
            $display("FAIL alias got=%h exp=cafef00d", read_data); end
        idle;
        tick;
        total++;
        if (read_data !== 32'h0BAD0BAD) begin bad++;
            $display("FAIL alias_top got=%h exp=0bad0bad", read_data); end
    endtask

    task automatic test_back_to_back;
        drive(2'b00, 3'b001, 32'h0, 32'h50, 1'b0, 32'h66, 5'd0);
        tick;
        drive(2'b11, 3'b011, 32'h0, 32'h50, 1'b0, 32'h77, 5'd2);
        tick;
        drive(2'b10, 3'b010, 32'h0, 32'h50, 1'b0, 32'h0, 5'd3);
        tick;
        total++;
        if (read_data !== 32'h66) begin bad++;
            $display("FAIL rw_old got=%h exp=66", read_data); end
        drive(2'b10, 3'b000, 32'h0, 32'h50, 1'b0, 32'h0, 5'd9);
        tick;
        total++;
        if (read_data !== 32'h77) begin bad++;
            $display("FAIL rw_new got=%h exp=77", read_data); end
        total++;
        if (write_reg !== 5'd3) begin bad++;
            $display("FAIL rw_wreg got=%0d exp=3", write_reg); end
        idle;
        tick;
        total++;
        if (read_data !== 32'h0) begin bad++;
            $display("FAIL noread got=%h exp=0", read_data); end
        total++;
        if (wb_out !== 2'b10) begin bad++;
            $display("FAIL noread_wb got=%b exp=10", wb_out); end
        total++;
        if (alu_result_out !== 32'h50) begin bad++;
            $display("FAIL noread_alu got=%h exp=50", alu_result_out); end
    endtask

    task automatic test_reset_write;
        drive(2'b00, 3'b001, 32'h0, 32'h30, 1'b0, 32'h1111, 5'd0);
        tick;
        drive(2'b00, 3'b001, 32'h0, 32'h30, 1'b0, 32'h2222, 5'd0);
        tick;
        idle;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        total++;
        if (wb_out !== 2'b00 || pcsrc !== 1'b0) begin bad++;
            $display("FAIL rstw_clear got=%b/%b exp=00/0", wb_out, pcsrc); end
        drive(2'b11, 3'b010, 32'h0, 32'h30, 1'b0, 32'h0, 5'd1);
        tick;
        idle;
        tick;
        total++;
        if (read_data !== 32'h1111) begin bad++;
            $display("FAIL rst_nowrite got=%h exp=1111", read_data); end
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        idle;
        test_reset;
        test_store_load;
        test_branch;
        test_flush;
        test_misaligned;
        test_alias;
        test_back_to_back;
        test_reset_write;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
